// File: rtl/button_pkg.sv
// Shared event codes and per-button FSM state encodings for the button event controller.
package button_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_LONG    = 2'b11
  } evt_code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_HELD    = 2'b10
  } btn_state_t;

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: 2-flop synchronizer, debounce counter, hold counter and press/long/release FSM.
module btn_debounce_fsm
  import button_pkg::*;
#(
  parameter int DB_CYCLES   = 16,
  parameter int LONG_CYCLES = 50000000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      btn_raw,
  output logic      level,
  output logic      evt_raise,
  output evt_code_t evt_code
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  logic              sync_p0;
  logic              sync_p1;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              toggle;
  logic              rise;
  logic              fall;
  logic              hold_done;
  btn_state_t        state;
  btn_state_t        state_nxt;

  // Synchronizer stage boundary: raw pin -> p0 -> p1
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // The FSM sees the level change in the same cycle it commits, so the event lands with the new level.
  assign toggle    = (sync_p1 != level) && (db_cnt == DB_W'(DB_CYCLES - 1));
  assign rise      = toggle & ~level;
  assign fall      = toggle & level;
  assign hold_done = (state == ST_PRESSED) && (hold_cnt == HOLD_W'(LONG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync_p1 == level) begin
      db_cnt <= '0;
    end else if (toggle) begin
      db_cnt <= '0;
      level  <= ~level;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (state_nxt == ST_IDLE) begin
      hold_cnt <= '0;
    end else if (state != ST_IDLE && hold_cnt != HOLD_W'(LONG_CYCLES)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (rise) state_nxt = ST_PRESSED;
      ST_PRESSED: begin
        if (fall)           state_nxt = ST_IDLE;
        else if (hold_done) state_nxt = ST_HELD;
      end
      ST_HELD:    if (fall) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    evt_raise = 1'b0;
    evt_code  = EVT_NONE;
    case (state)
      ST_IDLE: if (rise) begin
        evt_raise = 1'b1;
        evt_code  = EVT_PRESS;
      end
      ST_PRESSED: begin
        if (fall) begin
          evt_raise = 1'b1;
          evt_code  = EVT_RELEASE;
        end else if (hold_done) begin
          evt_raise = 1'b1;
          evt_code  = EVT_LONG;
        end
      end
      ST_HELD: if (fall) begin
        evt_raise = 1'b1;
        evt_code  = EVT_RELEASE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Debounced multi-button event source: per-button pending slots, round-robin arbiter, ready/valid output.
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int DB_CYCLES   = 16,
  parameter int LONG_CYCLES = 50000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_in,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic [1:0]               evt_type,
  output logic [N_BTN-1:0]         ovf,
  input  logic                     ovf_clr
);

  localparam int ID_W = $clog2(N_BTN);

  logic [N_BTN-1:0] raise;
  evt_code_t        raise_code [N_BTN];
  logic [N_BTN-1:0] pend_vld;
  evt_code_t        pend_type  [N_BTN];
  logic [N_BTN-1:0] drain;
  logic [N_BTN-1:0] ovf_set;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  idx;
  logic             found;
  logic             load;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce_fsm #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_btn (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_in[g]),
      .level    (btn_level[g]),
      .evt_raise(raise[g]),
      .evt_code (raise_code[g])
    );
  end

  assign load = ~evt_valid | evt_ready;

  // First pending slot at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_BTN);
      if (!found && pend_vld[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    drain = '0;
    if (load && found) drain[win] = 1'b1;
  end

  assign ovf_set = raise & pend_vld & ~drain;

  // Pending stage boundary: raised events wait here until the arbiter picks them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_vld <= '0;
      for (int i = 0; i < N_BTN; i++) pend_type[i] <= EVT_NONE;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (raise[i] && !ovf_set[i]) begin
          pend_vld[i]  <= 1'b1;
          pend_type[i] <= raise_code[i];
        end else if (drain[i]) begin
          pend_vld[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ovf <= '0;
    else      ovf <= (ovf_clr ? '0 : ovf) | ovf_set;
  end

  // Output stage boundary: holds the event steady until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= EVT_NONE;
      ptr       <= '0;
    end else if (load) begin
      evt_valid <= found;
      if (found) begin
        evt_id   <= win;
        evt_type <= pend_type[win];
        ptr      <= (win == ID_W'(N_BTN - 1)) ? '0 : win + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_button_event_ctrl;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int LG = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic [3:0] ovf;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  button_event_ctrl #(.N_BTN(N), .DB_CYCLES(DB), .LONG_CYCLES(LG)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .evt_type (evt_type),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  // Behavioural model state
  bit         m_s1 [N];
  bit         m_s2 [N];
  bit         m_lvl[N];
  bit         m_down[N];
  bit         m_long[N];
  bit         m_pv [N];
  bit         m_ov [N];
  int         m_run[N];
  int         m_age[N];
  logic [1:0] m_pt [N];
  bit         m_valid;
  int         m_id;
  logic [1:0] m_type;
  int         m_ptr;

  logic [1:0] qid[$];
  logic [1:0] qty[$];
  int         qt[$];

  task automatic model_step();
    bit         rz[N];
    logic [1:0] rc[N];
    int         w;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_down[i] = 0; m_long[i] = 0;
        m_pv[i] = 0; m_ov[i] = 0; m_run[i] = 0; m_age[i] = 0; m_pt[i] = 2'b00;
      end
      m_valid = 0; m_id = 0; m_type = 2'b00; m_ptr = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      bit tog;
      rz[i] = 0;
      rc[i] = 2'b00;
      tog = (m_s2[i] != m_lvl[i]) && (m_run[i] == DB - 1);
      if (tog && !m_lvl[i]) begin
        rz[i] = 1; rc[i] = 2'b01; m_down[i] = 1; m_age[i] = 0; m_long[i] = 0;
      end else if (tog && m_lvl[i]) begin
        rz[i] = 1; rc[i] = 2'b10; m_down[i] = 0;
      end else if (m_down[i]) begin
        if (!m_long[i] && m_age[i] == LG - 1) begin
          rz[i] = 1; rc[i] = 2'b11; m_long[i] = 1;
        end
        if (m_age[i] < LG) m_age[i]++;
      end
      m_run[i] = (m_s2[i] != m_lvl[i] && !tog) ? m_run[i] + 1 : 0;
      if (tog) m_lvl[i] = !m_lvl[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = btn_in[i];
    end
    // winner = pending index at the smallest circular distance from the pointer
    w = -1;
    for (int j = 0; j < N; j++)
      if (m_pv[j] && (w < 0 || ((j - m_ptr + N) % N) < ((w - m_ptr + N) % N))) w = j;
    if (!m_valid || evt_ready) begin
      if (w >= 0) begin
        m_valid = 1; m_id = w; m_type = m_pt[w]; m_pv[w] = 0; m_ptr = (w + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    if (ovf_clr) for (int i = 0; i < N; i++) m_ov[i] = 0;
    for (int i = 0; i < N; i++) begin
      if (rz[i]) begin
        if (m_pv[i]) m_ov[i] = 1;
        else begin m_pv[i] = 1; m_pt[i] = rc[i]; end
      end
    end
  endtask

  function automatic logic [12:0] model_vec();
    logic [3:0] l;
    logic [3:0] o;
    for (int i = 0; i < N; i++) begin
      l[i] = m_lvl[i];
      o[i] = m_ov[i];
    end
    return {l, m_valid, 2'(m_id), m_type, o};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0; btn_in = 4'hF; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if ({btn_level, evt_valid, evt_id, evt_type, ovf} !== 13'b0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%h expected=0", cyc,
                 {btn_level, evt_valid, evt_id, evt_type, ovf});
      end
    end
    rst = 1'b1;
    n = -1;
    for (int k = 1; k <= 20 && n < 0; k++) begin
      step();
      checks++;
      if ({btn_level, evt_valid, evt_id, evt_type, ovf} !== model_vec()) begin
        failures++;
        $display("FAIL reset_model cyc=%0d got=%h expected=%h", cyc,
                 {btn_level, evt_valid, evt_id, evt_type, ovf}, model_vec());
      end
      if (btn_level === 4'hF) n = k;
    end
    checks++;
    if (n !== 2 + DB) begin
      failures++;
      $display("FAIL held_through_reset latency got=%0d expected=%0d", n, 2 + DB);
    end
    btn_in = 4'h0; evt_ready = 1'b1;
    repeat (30) begin
      step();
      checks++;
      if ({btn_level, evt_valid, evt_id, evt_type, ovf} !== model_vec()) begin
        failures++;
        $display("FAIL reset_drain cyc=%0d got=%h expected=%h", cyc,
                 {btn_level, evt_valid, evt_id, evt_type, ovf}, model_vec());
      end
    end
  endtask

  task automatic test_glitch();
    evt_ready = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      btn_in = (k <= 3) ? 4'b0001 : 4'b0000;
      step();
      checks++;
      if (btn_level !== 4'b0 || evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL glitch k=%0d level=%b valid=%b expected level=0000 valid=0", k, btn_level, evt_valid);
      end
    end
  endtask

  task automatic collect(input int len_hi, input int len_total, input logic [3:0] pat, input string tag);
    qid.delete(); qty.delete(); qt.delete();
    for (int k = 1; k <= len_total; k++) begin
      btn_in = (k <= len_hi) ? pat : 4'b0000;
      step();
      checks++;
      if ({btn_level, evt_valid, evt_id, evt_type, ovf} !== model_vec()) begin
        failures++;
        $display("FAIL %s_model cyc=%0d got=%h expected=%h", tag, cyc,
                 {btn_level, evt_valid, evt_id, evt_type, ovf}, model_vec());
      end
      if (evt_valid === 1'b1) begin
        qid.push_back(evt_id); qty.push_back(evt_type); qt.push_back(k);
      end
    end
  endtask

  task automatic test_clean_press();
    int rise_t;
    evt_ready = 1'b1;
    rise_t = -1;
    qid.delete(); qty.delete(); qt.delete();
    for (int k = 1; k <= 30; k++) begin
      btn_in = (k <= 10) ? 4'b0001 : 4'b0000;
      step();
      if (btn_level[0] === 1'b1 && rise_t < 0) rise_t = k;
      if (evt_valid === 1'b1) begin
        qid.push_back(evt_id); qty.push_back(evt_type); qt.push_back(k);
      end
    end
    checks++;
    if (rise_t !== 6) begin
      failures++;
      $display("FAIL clean_level_rise edge got=%0d expected=6", rise_t);
    end
    checks++;
    if (qt.size() !== 2 || qt[0] !== 7 || qid[0] !== 2'd0 || qty[0] !== 2'b01) begin
      failures++;
      $display("FAIL clean_press events=%0d first_edge=%0d id=%0d type=%b expected 2,7,0,01",
               qt.size(), (qt.size() > 0) ? qt[0] : -1, (qid.size() > 0) ? qid[0] : 2'd0,
               (qty.size() > 0) ? qty[0] : 2'b00);
    end
    checks++;
    if (qty.size() < 2 || qty[1] !== 2'b10 || qid[1] !== 2'd0) begin
      failures++;
      $display("FAIL clean_release events=%0d type=%b expected type=10 id=0", qty.size(),
               (qty.size() > 1) ? qty[1] : 2'b00);
    end
  endtask

  task automatic test_long();
    evt_ready = 1'b1;
    collect(40, 60, 4'b0100, "long");
    checks++;
    if (qty.size() !== 3 || qty[0] !== 2'b01 || qty[1] !== 2'b11 || qty[2] !== 2'b10) begin
      failures++;
      $display("FAIL long_sequence events=%0d expected press,long,release", qty.size());
    end
    checks++;
    if (qid.size() !== 3 || qid[0] !== 2'd2 || qid[1] !== 2'd2 || qid[2] !== 2'd2) begin
      failures++;
      $display("FAIL long_ids events=%0d expected three events with id=2", qid.size());
    end
    checks++;
    if (qt.size() < 2 || qt[1] - qt[0] !== LG) begin
      failures++;
      $display("FAIL long_timing gap=%0d expected=%0d", (qt.size() > 1) ? qt[1] - qt[0] : -1, LG);
    end
  endtask

  task automatic rr_pair(input logic [3:0] pat, input logic [1:0] first, input logic [1:0] second);
    bit got;
    evt_ready = 1'b0; btn_in = pat; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (evt_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got || evt_id !== first) begin
      failures++;
      $display("FAIL rr_first pat=%b valid=%b id=%0d expected id=%0d", pat, evt_valid, evt_id, first);
    end
    repeat (3) begin
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== first || evt_type !== 2'b01) begin
        failures++;
        $display("FAIL rr_stall valid=%b id=%0d type=%b expected 1,%0d,01", evt_valid, evt_id, evt_type, first);
      end
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== second || evt_type !== 2'b01) begin
      failures++;
      $display("FAIL rr_second valid=%b id=%0d type=%b expected 1,%0d,01", evt_valid, evt_id, evt_type, second);
    end
    evt_ready = 1'b1;
    collect(0, 20, 4'b0000, "rr_drain");
  endtask

  task automatic test_round_robin();
    rr_pair(4'b0110, 2'd1, 2'd2);
    rr_pair(4'b1010, 2'd3, 2'd1);
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      btn_in = (k <= 10 || k > 20) ? 4'b0001 : 4'b0000;
      step();
    end
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_type !== 2'b01 || ovf !== 4'b0001) begin
      failures++;
      $display("FAIL ovf_set valid=%b id=%0d type=%b ovf=%b expected 1,0,01,0001", evt_valid, evt_id, evt_type, ovf);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 4'b0000) begin
      failures++;
      $display("FAIL ovf_clr ovf=%b expected 0000", ovf);
    end
    evt_ready = 1'b1;
    step();
    checks++;
    if (evt_valid !== 1'b1 || evt_type !== 2'b10 || evt_id !== 2'd0) begin
      failures++;
      $display("FAIL ovf_pending valid=%b type=%b id=%0d expected 1,10,0", evt_valid, evt_type, evt_id);
    end
    step();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_dropped valid=%b expected 0", evt_valid);
    end
    collect(0, 20, 4'b0000, "ovf_drain");
  endtask

  task automatic test_random();
    logic [3:0] b;
    b = 4'b0000;
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 13) == 0) b[i] = ~b[i];
      btn_in    = b;
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 399) != 0);
      step();
      checks++;
      if ({btn_level, evt_valid, evt_id, evt_type, ovf} !== model_vec()) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%h expected=%h", cyc,
                 {btn_level, evt_valid, evt_id, evt_type, ovf}, model_vec());
      end
    end
    rst = 1'b1; ovf_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; btn_in = 4'h0; evt_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_glitch();
    test_clean_press();
    test_long();
    test_round_robin();
    test_overflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of button inputs (2..8).
REQ-002 SHALL have parameter DB_CYCLES, default 16, consecutive stable samples required to accept a level change (>=2).
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000, debounced-high cycles before a long-press event (> DB_CYCLES).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port btn_in  input  N_BTN  raw asynchronous button levels.
REQ-007 SHALL have port btn_level  output  N_BTN  debounced button levels.
REQ-008 SHALL have port evt_valid  output  1  event available.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-010 SHALL have port evt_id  output  clog2(N_BTN)  source button index.
REQ-011 SHALL have port evt_type  output  2  event code: 01 press, 10 release, 11 long.
REQ-012 SHALL have port ovf  output  N_BTN  sticky per-button dropped-event flags.
REQ-013 SHALL have port ovf_clr  input  1  one-cycle pulse clearing all ovf bits.

Function
REQ-014 SHALL pass each btn_in bit through a 2-flop synchronizer before any other use.
REQ-015 SHALL, per button, count cycles where the synchronized value differs from btn_level, clear the count when equal, and toggle btn_level plus clear the count when the count reaches DB_CYCLES.
REQ-016 SHALL make btn_level rise exactly 2+DB_CYCLES rising edges after the first edge sampling btn_in high, provided input stays high.
REQ-017 SHALL implement per button FSM IDLE -> PRESSED (level rise, raise press) -> HELD (hold count reaches LONG_CYCLES, raise long) and PRESSED/HELD -> IDLE (level fall, raise release).
REQ-018 SHALL raise at most one long event per press; hold counter saturates and clears on entry to IDLE.
REQ-019 SHALL store each raised event in a one-entry per-button pending register (valid + type).
REQ-020 SHALL, when an event is raised while that button's pending entry is occupied and not being drained that cycle, drop the new event and set ovf[i].
REQ-021 SHALL accept a new event into a pending entry that is being drained the same cycle without setting ovf.
REQ-022 SHALL hold evt_valid/evt_id/evt_type in an output register; the register loads when empty or on transfer (evt_valid & evt_ready).
REQ-023 SHALL select the loaded entry round-robin: first pending index at or after pointer ptr, wrapping; ptr becomes winner+1 mod N_BTN on load.
REQ-024 SHALL clear the winner's pending entry in the cycle it is loaded; evt_valid rises one cycle after the event is raised when the output register is empty.
REQ-025 SHALL keep evt_id/evt_type stable while evt_valid=1 and evt_ready=0.
REQ-026 SHALL give ovf set priority over ovf_clr in the same cycle.

Reset
REQ-027 SHALL, with rst=0 at a clk edge, clear synchronizers, counters, btn_level, FSMs (IDLE), pending entries, output register (evt_valid=0, evt_id=0, evt_type=00), ptr=0, ovf=0.
REQ-028 SHALL discard any in-progress debounce, hold count or undelivered event on reset mid-operation; a button held through reset produces a press after release of reset plus 2+DB_CYCLES edges.

Structure
REQ-029 SHALL place event codes (EVT_PRESS, EVT_RELEASE, EVT_LONG) and FSM state encodings in a shared package button_pkg.
REQ-030 SHALL implement synchronizer, debounce counter, hold counter and FSM in sub-module btn_debounce_fsm, instantiated N_BTN times; arbitration and output register stay in the top.

Verification (N_BTN=4, DB_CYCLES=4, LONG_CYCLES=20)
REQ-031 SHALL check reset: rst=0 for 3 cycles with btn_in=4'hF -> btn_level=0, evt_valid=0, ovf=0 throughout.
REQ-032 SHALL check glitch rejection: btn_in[0] high 3 cycles then low -> no btn_level change, no event.
REQ-033 SHALL check clean press: btn_in[0] high 10 cycles, evt_ready=1 -> btn_level[0] rises at edge 6, evt_valid at edge 7 with id=0 type=01; release yields type=10.
REQ-034 SHALL check long press: btn_in[2] high 40 cycles -> events press, long (once, 20 cycles after level rise), release, in that order, id=2.
REQ-035 SHALL check round-robin: btn1 and btn2 pressed together, evt_ready=0 then 1 -> id1 then id2; next simultaneous btn1 and btn3 with ptr=3 -> id3 then id1.
REQ-036 SHALL check overflow: evt_ready=0, btn0 press/release/press -> press in output register, release pending, third event dropped, ovf=4'b0001; ovf_clr pulse -> ovf=0.
